// File: rtl/rs_alu_sched_pkg.sv
// rtl/rs_alu_sched_pkg.sv - shared widths, sizes, opcodes and age compare for the ALU reservation station
package rs_alu_sched_pkg;

  localparam int RS_SIZE = 16;
  localparam int IDX_W   = $clog2(RS_SIZE);
  localparam int AGE_W   = IDX_W + 1;
  localparam int ROB_W   = 4;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_ADDI = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_BEQ  = 6'd16,
    OP_JAL  = 6'd24,
    OP_JALR = 6'd25
  } op_e;

  // Wrap-aware: a is older than b when (a - b) is negative in AGE_W bits.
  function automatic logic age_older(input logic [AGE_W-1:0] a, input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] diff;
    diff = a - b;
    return diff[AGE_W-1];
  endfunction

endpackage

// File: rtl/rs_alu_sched_if.sv
// rtl/rs_alu_sched_if.sv - dispatcher, result-bus and ALU issue signals of the reservation station
interface rs_alu_sched_if;
  import rs_alu_sched_pkg::*;

  logic              alloc_valid;
  logic [OP_W-1:0]   alloc_op;
  logic [31:0]       alloc_pc;
  logic [31:0]       alloc_imm;
  logic [ROB_W-1:0]  alloc_rd;
  logic              alloc_j_ready;
  logic [DATA_W-1:0] alloc_vj;
  logic [ROB_W-1:0]  alloc_qj;
  logic              alloc_k_ready;
  logic [DATA_W-1:0] alloc_vk;
  logic [ROB_W-1:0]  alloc_qk;
  logic              rs_full;

  logic              cdb0_valid;
  logic [ROB_W-1:0]  cdb0_tag;
  logic [DATA_W-1:0] cdb0_data;
  logic              cdb1_valid;
  logic [ROB_W-1:0]  cdb1_tag;
  logic [DATA_W-1:0] cdb1_data;

  logic              alu_enable;
  logic [OP_W-1:0]   alu_op;
  logic [ROB_W-1:0]  alu_rd;
  logic [31:0]       alu_pc;
  logic [31:0]       alu_imm;
  logic [DATA_W-1:0] alu_rs1;
  logic [DATA_W-1:0] alu_rs2;

  modport master (
    output alloc_valid, alloc_op, alloc_pc, alloc_imm, alloc_rd,
           alloc_j_ready, alloc_vj, alloc_qj, alloc_k_ready, alloc_vk, alloc_qk,
           cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data,
    input  rs_full, alu_enable, alu_op, alu_rd, alu_pc, alu_imm, alu_rs1, alu_rs2
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_pc, alloc_imm, alloc_rd,
           alloc_j_ready, alloc_vj, alloc_qj, alloc_k_ready, alloc_vk, alloc_qk,
           cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data,
    output rs_full, alu_enable, alu_op, alu_rd, alu_pc, alu_imm, alu_rs1, alu_rs2
  );

endinterface

// File: rtl/rs_select.sv
// rtl/rs_select.sv - combinational picker: lowest-index request, or oldest age stamp when AGE_EN is set
module rs_select
  import rs_alu_sched_pkg::*;
#(
  parameter int N      = RS_SIZE,
  parameter int IW     = IDX_W,
  parameter int AW     = AGE_W,
  parameter bit AGE_EN = 1'b0
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0][AW-1:0] stamp,
  output logic                 issue_valid,
  output logic [IW-1:0]        issue_idx
);

  generate
    if (AGE_EN) begin : g_age
      logic          found;
      logic [AW-1:0] best;
      always_comb begin
        found     = 1'b0;
        best      = '0;
        issue_idx = '0;
        for (int i = 0; i < N; i++) begin
          if (req[i] && (!found || age_older(stamp[i], best))) begin
            found     = 1'b1;
            best      = stamp[i];
            issue_idx = IW'(i);
          end
        end
        issue_valid = found;
      end
    end else begin : g_low
      logic unused_stamp;
      assign unused_stamp = ^stamp;
      always_comb begin
        issue_valid = 1'b0;
        issue_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (req[i]) begin
            issue_valid = 1'b1;
            issue_idx   = IW'(i);
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/rs_alu_sched.sv
// rtl/rs_alu_sched.sv - ALU reservation station and single-issue scheduler
// Define RS_OLDEST_FIRST_EN to issue the oldest ready entry instead of the lowest index.
module rs_alu_sched
  import rs_alu_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic jump_wrong,
  rs_alu_sched_if.slave bus
);

  localparam logic [IDX_W:0] FULL_AT = (IDX_W+1)'(RS_SIZE - 1);

  logic [RS_SIZE-1:0] busy;
  logic [RS_SIZE-1:0] j_ready;
  logic [RS_SIZE-1:0] k_ready;
  logic [OP_W-1:0]    e_op  [RS_SIZE];
  logic [31:0]        e_pc  [RS_SIZE];
  logic [31:0]        e_imm [RS_SIZE];
  logic [ROB_W-1:0]   e_rd  [RS_SIZE];
  logic [DATA_W-1:0]  e_vj  [RS_SIZE];
  logic [ROB_W-1:0]   e_qj  [RS_SIZE];
  logic [DATA_W-1:0]  e_vk  [RS_SIZE];
  logic [ROB_W-1:0]   e_qk  [RS_SIZE];
  logic [IDX_W:0]     count;
  logic [IDX_W:0]     count_next;

  logic               iss_valid;
  logic [IDX_W-1:0]   iss_idx;
  logic               free_valid;
  logic [IDX_W-1:0]   free_idx;
  logic               do_alloc;
  logic               do_issue;
  logic               a_j_ready;
  logic               a_k_ready;
  logic [DATA_W-1:0]  a_vj;
  logic [DATA_W-1:0]  a_vk;

`ifdef RS_OLDEST_FIRST_EN
  logic [RS_SIZE-1:0][AGE_W-1:0] age;
  logic [AGE_W-1:0]              age_cnt;

  rs_select #(.AGE_EN(1'b1)) u_issue_sel (
    .req(busy & j_ready & k_ready), .stamp(age),
    .issue_valid(iss_valid), .issue_idx(iss_idx)
  );
`else
  rs_select #(.AGE_EN(1'b0)) u_issue_sel (
    .req(busy & j_ready & k_ready), .stamp('0),
    .issue_valid(iss_valid), .issue_idx(iss_idx)
  );
`endif

  rs_select #(.AGE_EN(1'b0)) u_free_sel (
    .req(~busy), .stamp('0),
    .issue_valid(free_valid), .issue_idx(free_idx)
  );

  assign do_alloc   = bus.alloc_valid & rdy & free_valid;
  assign do_issue   = rdy & iss_valid;
  assign count_next = count + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_issue);

  // Same-cycle bypass: a result broadcast now must not be missed by the new entry.
  always_comb begin
    a_j_ready = bus.alloc_j_ready;
    a_vj      = bus.alloc_vj;
    a_k_ready = bus.alloc_k_ready;
    a_vk      = bus.alloc_vk;
    if (!bus.alloc_j_ready) begin
      if (bus.cdb0_valid && bus.cdb0_tag == bus.alloc_qj) begin
        a_j_ready = TRUE;
        a_vj      = bus.cdb0_data;
      end else if (bus.cdb1_valid && bus.cdb1_tag == bus.alloc_qj) begin
        a_j_ready = TRUE;
        a_vj      = bus.cdb1_data;
      end
    end
    if (!bus.alloc_k_ready) begin
      if (bus.cdb0_valid && bus.cdb0_tag == bus.alloc_qk) begin
        a_k_ready = TRUE;
        a_vk      = bus.cdb0_data;
      end else if (bus.cdb1_valid && bus.cdb1_tag == bus.alloc_qk) begin
        a_k_ready = TRUE;
        a_vk      = bus.cdb1_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || jump_wrong) begin
      busy           <= '0;
      count          <= '0;
      bus.rs_full    <= FALSE;
      bus.alu_enable <= FALSE;
      bus.alu_op     <= '0;
      bus.alu_rd     <= '0;
      bus.alu_pc     <= '0;
      bus.alu_imm    <= '0;
      bus.alu_rs1    <= '0;
      bus.alu_rs2    <= '0;
`ifdef RS_OLDEST_FIRST_EN
      age_cnt        <= '0;
`endif
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !j_ready[i]) begin
          if (bus.cdb0_valid && bus.cdb0_tag == e_qj[i]) begin
            j_ready[i] <= TRUE;
            e_vj[i]    <= bus.cdb0_data;
          end else if (bus.cdb1_valid && bus.cdb1_tag == e_qj[i]) begin
            j_ready[i] <= TRUE;
            e_vj[i]    <= bus.cdb1_data;
          end
        end
        if (busy[i] && !k_ready[i]) begin
          if (bus.cdb0_valid && bus.cdb0_tag == e_qk[i]) begin
            k_ready[i] <= TRUE;
            e_vk[i]    <= bus.cdb0_data;
          end else if (bus.cdb1_valid && bus.cdb1_tag == e_qk[i]) begin
            k_ready[i] <= TRUE;
            e_vk[i]    <= bus.cdb1_data;
          end
        end
      end

      bus.alu_enable <= iss_valid;
      if (iss_valid) begin
        busy[iss_idx] <= FALSE;
        bus.alu_op    <= e_op[iss_idx];
        bus.alu_rd    <= e_rd[iss_idx];
        bus.alu_pc    <= e_pc[iss_idx];
        bus.alu_imm   <= e_imm[iss_idx];
        bus.alu_rs1   <= e_vj[iss_idx];
        bus.alu_rs2   <= e_vk[iss_idx];
      end

      // The free slot is never busy, so it cannot collide with wakeup or issue above.
      if (do_alloc) begin
        busy[free_idx]    <= TRUE;
        e_op[free_idx]    <= bus.alloc_op;
        e_pc[free_idx]    <= bus.alloc_pc;
        e_imm[free_idx]   <= bus.alloc_imm;
        e_rd[free_idx]    <= bus.alloc_rd;
        j_ready[free_idx] <= a_j_ready;
        e_vj[free_idx]    <= a_vj;
        e_qj[free_idx]    <= bus.alloc_qj;
        k_ready[free_idx] <= a_k_ready;
        e_vk[free_idx]    <= a_vk;
        e_qk[free_idx]    <= bus.alloc_qk;
`ifdef RS_OLDEST_FIRST_EN
        age[free_idx]     <= age_cnt;
        age_cnt           <= age_cnt + AGE_W'(1);
`endif
      end

      count       <= count_next;
      bus.rs_full <= (count_next >= FULL_AT);
    end else begin
      bus.alu_enable <= FALSE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !jump_wrong && rdy) begin
      assert (!(bus.alloc_valid && !free_valid));
      assert (!(bus.cdb0_valid && bus.cdb1_valid && bus.cdb0_tag == bus.cdb1_tag));
    end
  end

endmodule

// File: doc/rs_alu_sched.md
Name: rs_alu_sched

Overview:
- Reservation station plus issue scheduler in front of the integer ALU.
- Accepts renamed instructions from the dispatcher and holds them until both operands are valid.
- Captures operands from the two result broadcast buses (ALU and load/store), then issues at most one ready entry per cycle to the ALU.
- Discards all contents on branch mispredict.

Parameters:
- RS_SIZE, 16, number of entries (power of two).
- ROB_W, 4, ROB tag width.
- DATA_W, 32, operand/result width.
- OP_W, 6, internal opcode width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- jump_wrong  in  1  mispredict flush
- alloc_valid  in  1  dispatcher presents instruction
- alloc_op  in  OP_W  opcode
- alloc_pc  in  32  instruction PC
- alloc_imm  in  32  sign-extended immediate
- alloc_rd  in  ROB_W  destination ROB tag
- alloc_j_ready  in  1  rs1 value valid
- alloc_vj  in  DATA_W  rs1 value
- alloc_qj  in  ROB_W  rs1 producer tag
- alloc_k_ready  in  1  rs2 value valid
- alloc_vk  in  DATA_W  rs2 value
- alloc_qk  in  ROB_W  rs2 producer tag
- rs_full  out  1  registered; dispatcher must not allocate when high
- cdb0_valid  in  1  ALU broadcast
- cdb0_tag  in  ROB_W  ALU result tag
- cdb0_data  in  DATA_W  ALU result
- cdb1_valid  in  1  load/store broadcast
- cdb1_tag  in  ROB_W  load/store result tag
- cdb1_data  in  DATA_W  load/store result
- alu_enable  out  1  issue strobe to ALU
- alu_op  out  OP_W  opcode
- alu_rd  out  ROB_W  destination tag
- alu_pc  out  32  PC
- alu_imm  out  32  immediate
- alu_rs1  out  DATA_W  rs1 value
- alu_rs2  out  DATA_W  rs2 value

Behaviour:
- Per entry: busy, op, pc, imm, rd, j_ready, vj, qj, k_ready, vk, qk.
- Reset or jump_wrong (synchronous, has priority over rdy):
  - All busy cleared; count=0.
  - rs_full=0, alu_enable=0.
  - All other outputs reset to 0.
  - An alloc in that cycle is dropped.
- rdy=0: no state change, no allocation, and alu_enable is driven 0 at the next edge.
- Allocation (alloc_valid & rdy):
  - Writes the lowest-index free entry.
  - If either CDB in the same cycle matches alloc_qj/alloc_qk of a not-ready operand, the CDB data is captured and the operand marked ready (same-cycle bypass).
  - Allocation while no free entry exists is a protocol error: ignored and flagged by assertion.
- Wakeup: each cycle, every busy entry with a not-ready operand whose q equals a valid CDB tag captures that data.
  - If both buses match, cdb0 wins. The bench never produces this case; it is an assertion.
- Select:
  - An entry is ready iff busy & j_ready & k_ready, evaluated on registered state, so a wakeup becomes issuable the following cycle.
  - Among ready entries one is chosen (see Optional Feature).
  - At the next edge: alu_enable=1, the ALU fields are loaded from the entry, and the entry's busy is cleared.
  - No ready entry: alu_enable=0 and the other outputs hold.
- Latency:
  - Alloc with both operands ready gives alu_enable at the edge after next (one cycle in RS).
  - CDB wakeup to issue is 2 edges.
- count = busy entries.
  - Allocation and issue in the same cycle leave count unchanged.
  - rs_full registered = (next count >= RS_SIZE-1), which gives the dispatcher one cycle of slack.
- Branches, JAL and JALR are scheduled identically; the op is passed through untouched.

Optional Feature:
- Macro: RS_OLDEST_FIRST_EN.
- Defined:
  - Each entry stores an age stamp from a (log2(RS_SIZE)+1)-bit allocation counter.
  - Select picks the ready entry with the oldest stamp, compared with wrap-aware subtraction.
  - The counter resets to 0 on rst/jump_wrong.
- Undefined: select picks the lowest-index ready entry; no stamp storage.

Decomposition:
- Shared package/define file holds:
  - Opcode encodings.
  - ROB tag width, DATA_W.
  - RS_SIZE.
  - TRUE/FALSE constants.
- Sub-module rs_select: combinational priority/age picker. Input is the ready vector (and stamps); outputs are issue_valid and issue_idx.
- A second, identical use of rs_select finds the free slot (lowest-index) for allocation.

Test Plan:
- Reset then ADD rd=3, vj=5, vk=7, both ready → one cycle later alu_enable=1, alu_op=ADD, alu_rd=3, rs1=5, rs2=7; rs_full=0.
- ADDI qj=2 not ready; cdb1 tag=2 data=0x10 two cycles later → issue exactly 2 edges after the CDB, rs1=0x10.
- Alloc with qk=4 in the same cycle as cdb0 tag=4 data=9 → entry captures 9 and issues next edge with rs2=9.
- Fill 15 entries with unready operands → rs_full=1 after the 15th; broadcast wakes one entry → issue, and rs_full drops the cycle after.
- 6 entries waiting, jump_wrong pulse while cdb0 fires → no issue next cycle, count=0, rs_full=0; a new alloc after the flush issues normally.
- Oldest-first build: allocate A (idx0, unready), B (idx1, ready), then wake A → B issues first; with feature on and A then B both ready, A issues before B even after index reuse wraps the age counter.
